// File: rtl/fta_bus_pkg.sv
// FTA bus command/response types shared across the codebase, plus the
// request arbiter's FSM state enum.
package fta_bus_pkg;

  localparam int FTA_CID_W = 4;
  localparam int FTA_PRI_W = 4;

  typedef struct packed {
    logic                 cyc;
    logic                 we;
    logic [FTA_PRI_W-1:0] pri;
    logic [FTA_CID_W-1:0] cid;
    logic [7:0]           tid;
    logic [15:0]          sel;
    logic [31:0]          adr;
    logic [127:0]         dat;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic                 ack;
    logic                 err;
    logic [FTA_CID_W-1:0] cid;
    logic [7:0]           tid;
    logic [127:0]         dat;
  } fta_cmd_response128_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } fta_arb_state_t;

endpackage

// File: rtl/fta_req_arbiter_rr_sel.sv
// Combinational round-robin picker (module fta_rr_sel): returns the first set
// bit of elig_i, searching upward from last_grant_i+1 and wrapping to 0.
module fta_rr_sel #(
  parameter  int CHANNELS = 8,
  localparam int IDX_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] elig_i,
  input  logic [IDX_W-1:0]    last_grant_i,
  output logic [IDX_W-1:0]    sel_o,
  output logic                found_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    sel_o   = '0;
    found_o = 1'b0;
    idx     = '0;
    // CHANNELS is a power of two, so the index wraps by plain truncation.
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = last_grant_i + IDX_W'(i);
      if (!found_o && elig_i[idx]) begin
        sel_o   = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fta_req_arbiter.sv
// FTA request arbiter: CHANNELS requesters share one bus master port, responses return by cid.
// Define FTA_ARB_PRIORITY_EN to pick the lowest req.pri first (ties round-robin).
module fta_req_arbiter
  import fta_bus_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int MAX_OUT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  fta_cmd_request128_t  req       [CHANNELS],
  output logic [CHANNELS-1:0]  req_ack_o,
  output fta_cmd_request128_t  req_o,
  input  logic                 bus_stall_i,
  input  fta_cmd_response128_t resp_i,
  output fta_cmd_response128_t resp_o    [CHANNELS],
  output logic                 err_o
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  fta_arb_state_t       state_q, state_d;
  fta_cmd_request128_t  req_q, req_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  cnt_t                 outcnt_q [CHANNELS];
  cnt_t                 outcnt_d [CHANNELS];
  fta_cmd_response128_t resp_q   [CHANNELS];
  fta_cmd_response128_t resp_d   [CHANNELS];
  logic                 err_q, err_d;

  logic [CHANNELS-1:0]  elig, cand;
  logic [IDX_W-1:0]     sel;
  logic                 found;
  logic                 issue;
  logic                 rsp_in_range, rsp_route;
  logic [IDX_W-1:0]     rsp_ch;

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      elig[n] = req[n].cyc && (outcnt_q[n] < cnt_t'(MAX_OUT));
    end
  end

`ifdef FTA_ARB_PRIORITY_EN
  logic [FTA_PRI_W-1:0] min_pri;

  always_comb begin
    min_pri = '1;
    for (int n = 0; n < CHANNELS; n++) begin
      if (elig[n] && (req[n].pri < min_pri)) min_pri = req[n].pri;
    end
    for (int n = 0; n < CHANNELS; n++) begin
      cand[n] = elig[n] && (req[n].pri == min_pri);
    end
  end
`else
  assign cand = elig;
`endif

  fta_rr_sel #(.CHANNELS(CHANNELS)) u_rr_sel (
    .elig_i      (cand),
    .last_grant_i(last_grant_q),
    .sel_o       (sel),
    .found_o     (found)
  );

  // A response is routed only to a channel that really has a transaction in flight.
  assign rsp_in_range = (int'(resp_i.cid) < CHANNELS);
  assign rsp_ch       = rsp_in_range ? resp_i.cid[IDX_W-1:0] : '0;
  assign rsp_route    = resp_i.ack && rsp_in_range && (outcnt_q[rsp_ch] != '0);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    issue        = 1'b0;
    req_ack_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_d     = req[sel];
          req_d.cid = FTA_CID_W'(sel);
          grant_d   = sel;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus_stall_i) begin
          issue              = 1'b1;
          req_ack_o[grant_q] = 1'b1;
          last_grant_d       = grant_q;
          req_d              = '0;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic inc, dec;
    inc   = 1'b0;
    dec   = 1'b0;
    err_d = err_q | (resp_i.ack & ~rsp_route);
    for (int n = 0; n < CHANNELS; n++) begin
      resp_d[n]   = '0;
      outcnt_d[n] = outcnt_q[n];
      inc = issue && (grant_q == IDX_W'(n));
      dec = rsp_route && (rsp_ch == IDX_W'(n));
      if (dec) resp_d[n] = resp_i;
      if (inc && !dec) outcnt_d[n] = outcnt_q[n] + cnt_t'(1);
      else if (dec && !inc) outcnt_d[n] = outcnt_q[n] - cnt_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(CHANNELS - 1);
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // NOTE: these per-channel arrays are visible state (counters, outputs), so unlike a data RAM they are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        outcnt_q[n] <= '0;
        resp_q[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        outcnt_q[n] <= outcnt_d[n];
        resp_q[n]   <= resp_d[n];
      end
    end
  end

  assign req_o  = req_q;
  assign resp_o = resp_q;
  assign err_o  = err_q;

endmodule
